cordic_phase_scheduler: RTL

//  Time-shares one 23-stage pipelined cordic between NUM_CH independent phase channels (DDS style).

---
 rtl/cordic_phase_scheduler_if.sv | 47 ++++
 rtl/cordic_phase_scheduler.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cordic_phase_scheduler_if.sv
// ----------------------------------------------------------------------------
// cordic_phase_scheduler_if
//   Bundles the cordic issue/return bus and the tagged result bus of the
//   cordic phase scheduler.
//
//   Handshake semantics: every bus here is valid-only. A strobe
//   (o_cordic_valid, i_cordic_valid, o_valid) marks a one-cycle beat whose
//   data lines are meaningful in that same cycle. There is no ready or
//   backpressure, because the cordic is fully pipelined and always accepts.
//
//   master : the scheduler (drives cordic inputs and results, receives cordic outputs)
//   slave  : the cordic plus the result consumer
//
//   o_cordic_valid/_x/_y/_z : issue beat to cordic (x = AMP, y = 0, z = phase)
//   i_cordic_valid/_x/_y    : cordic output beat (cos, sin)
//   o_valid/o_ch            : result strobe and the channel it belongs to
//   o_cos/o_sin             : cordic x/y passed through, aligned to o_valid
//   o_err                   : sticky tag-line/cordic valid disagreement
// ----------------------------------------------------------------------------
interface cordic_phase_scheduler_if #(
    parameter int CH_W = 2
);
    logic            o_cordic_valid;
    logic [23:0]     o_cordic_x;
    logic [23:0]     o_cordic_y;
    logic [23:0]     o_cordic_z;
    logic            i_cordic_valid;
    logic [23:0]     i_cordic_x;
    logic [23:0]     i_cordic_y;
    logic            o_valid;
    logic [CH_W-1:0] o_ch;
    logic [23:0]     o_cos;
    logic [23:0]     o_sin;
    logic            o_err;

    modport master (
        output o_cordic_valid, o_cordic_x, o_cordic_y, o_cordic_z,
        input  i_cordic_valid, i_cordic_x, i_cordic_y,
        output o_valid, o_ch, o_cos, o_sin, o_err
    );

    modport slave (
        input  o_cordic_valid, o_cordic_x, o_cordic_y, o_cordic_z,
        output i_cordic_valid, i_cordic_x, i_cordic_y,
        input  o_valid, o_ch, o_cos, o_sin, o_err
    );
endinterface

// File: rtl/cordic_phase_scheduler.sv
// ----------------------------------------------------------------------------
// cordic_phase_scheduler
//   Time-shares one pipelined cordic between NUM_CH DDS phase channels.
//   Each channel owns a 24-bit phase accumulator, increment and enable.
//   One enabled channel is issued per clock, round-robin; its phase goes
//   to the cordic and its id travels down a LATENCY-deep tag line so the
//   returning cos/sin can be labelled with the right channel.
//
// Ports
//   i_clk, i_arst_n : clock (rising edge), asynchronous active-low reset
//   i_run           : 1 = issue enabled, 0 = stop issuing (pipeline drains)
//   i_cfg_we        : write i_cfg_inc / i_cfg_en into channel i_cfg_ch
//   i_cfg_clr       : clear the accumulator of channel i_cfg_ch
//   i_cfg_ch        : target channel of cfg write / clear
//   i_cfg_inc       : phase increment, full turn = 2^24
//   i_cfg_en        : channel enable written with i_cfg_we
//   bus (master)    : cordic issue/return and tagged result signals
// ----------------------------------------------------------------------------
module cordic_phase_scheduler #(
    parameter int          NUM_CH  = 4,
    parameter int          LATENCY = 23,
    parameter logic [23:0] AMP     = 24'h26DD3B,
    localparam int         CH_W    = $clog2(NUM_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_run,
    input  logic                     i_cfg_we,
    input  logic                     i_cfg_clr,
    input  logic [CH_W-1:0]          i_cfg_ch,
    input  logic [23:0]              i_cfg_inc,
    input  logic                     i_cfg_en,
    cordic_phase_scheduler_if.master bus
);

    logic [23:0]     acc_q [NUM_CH];
    logic [23:0]     inc_q [NUM_CH];
    logic [NUM_CH-1:0] en_q;
    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] cand;
    logic            any_en;
    logic            issue;

    logic            cv_q;
    logic [23:0]     z_q;
    logic [CH_W-1:0] issue_ch_q;

    logic            tag_v_q  [LATENCY];
    logic [CH_W-1:0] tag_ch_q [LATENCY];
    logic            err_q;

    // Round-robin pick: scan downwards so the closest enabled channel after
    // the pointer is the last one to win the assignment.
    always_comb begin
        sel    = ptr_q;
        any_en = 1'b0;
        cand   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = CH_W'((int'(ptr_q) + k) % NUM_CH);
            if (en_q[cand]) begin
                sel    = cand;
                any_en = 1'b1;
            end
        end
    end

    assign issue = i_run & any_en;

    // Issue register: phase and channel of the beat presented to the cordic.
    // The phase holds when nothing is issued.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cv_q       <= 1'b0;
            z_q        <= '0;
            issue_ch_q <= '0;
            ptr_q      <= CH_W'(NUM_CH - 1);
        end else begin
            cv_q <= issue;
            if (issue) begin
                z_q        <= acc_q[sel];
                issue_ch_q <= sel;
                ptr_q      <= sel;
            end
        end
    end

    // Per-channel state. Clear wins over the accumulate of the same cycle;
    // the issue register above still captured the pre-clear phase.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= '0;
            end
            en_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (i_cfg_clr && i_cfg_ch == CH_W'(i)) begin
                    acc_q[i] <= '0;
                end else if (issue && sel == CH_W'(i)) begin
                    acc_q[i] <= acc_q[i] + inc_q[i];
                end
                if (i_cfg_we && i_cfg_ch == CH_W'(i)) begin
                    inc_q[i] <= i_cfg_inc;
                    en_q[i]  <= i_cfg_en;
                end
            end
        end
    end

    // Tag line mirrors the cordic pipeline: the last stage lines up with
    // i_cordic_valid when the cordic behaves.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int s = 0; s < LATENCY; s++) begin
                tag_v_q[s]  <= 1'b0;
                tag_ch_q[s] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            tag_v_q[0]  <= cv_q;
            tag_ch_q[0] <= issue_ch_q;
            for (int s = 1; s < LATENCY; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_ch_q[s] <= tag_ch_q[s-1];
            end
            err_q <= err_q | (bus.i_cordic_valid != tag_v_q[LATENCY-1]);
        end
    end

    assign bus.o_cordic_valid = cv_q;
    assign bus.o_cordic_x     = AMP;
    assign bus.o_cordic_y     = '0;
    assign bus.o_cordic_z     = z_q;
    assign bus.o_valid        = tag_v_q[LATENCY-1];
    assign bus.o_ch           = tag_ch_q[LATENCY-1];
    assign bus.o_cos          = bus.i_cordic_x;
    assign bus.o_sin          = bus.i_cordic_y;
    assign bus.o_err          = err_q;

endmodule
